// File: rtl/ifu_mem_pkg.sv
// Shared state encoding, LFSR constants and address decode for the IFU memory responder.
package ifu_mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // x^8+x^6+x^5+x^4+1, shift-left Fibonacci form: feedback = q[7]^q[5]^q[4]^q[3]
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [31:0] depth);
        logic [31:0] off;
        off = addr - base;
        return (addr[1:0] == 2'b00) && (addr >= base) && ({2'b00, off[31:2]} < depth);
    endfunction

endpackage

// File: rtl/ifu_mem_array.sv
// DEPTH x 32 word array: one write port, one registered read port (read-before-write).
module ifu_mem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)       r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ifu_mem_responder.sv
// Fetch-interface slave: one request at a time, fixed latency, response held until consumed.
// Optional IFU_MEM_RAND_DELAY_EN adds 0..3 LFSR-driven wait cycles per request.
module ifu_mem_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    input  logic        resp_ready,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);
    import ifu_mem_pkg::*;

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W = DEPTH;

    logic [1:0]    r_state;
    logic [4:0]    r_cnt;
    logic [31:0]   r_addr;
    logic          r_err;
    logic          r_resp_valid;

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_ld_ok;
    logic [4:0]    w_delay;
    logic [31:0]   w_rd_addr;
    logic [AW-1:0] w_rd_idx;
    logic [AW-1:0] w_ld_idx;
    logic [31:0]   w_rdata;

    assign req_ready = !rst && (r_state == ST_IDLE) && !load_en;
    assign w_accept  = req_valid && req_ready;

`ifdef IFU_MEM_RAND_DELAY_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) r_lfsr <= LFSR_SEED;
        else     r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
    end

    assign w_delay = 5'(LATENCY) + {3'b000, r_lfsr[1:0]};
`else
    assign w_delay = 5'(LATENCY);
`endif

    // The array is read on exactly the edge that enters RESP, so same-edge loads return old data.
    assign w_enter_resp = (w_accept && (w_delay == 5'd0)) ||
                          ((r_state == ST_WAIT) && (r_cnt == 5'd0));
    assign w_rd_addr    = w_accept ? req_addr : r_addr;
    assign w_rd_idx     = AW'((w_rd_addr - BASE_ADDR) >> 2);
    assign w_ld_idx     = AW'((load_addr - BASE_ADDR) >> 2);
    assign w_ld_ok      = load_en && addr_ok(load_addr, BASE_ADDR, DEPTH_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_err        <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr <= req_addr;
                        if (w_delay == 5'd0) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= w_delay - 5'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 5'd0) r_state <= ST_RESP;
                    else               r_cnt   <= r_cnt - 5'd1;
                end
                ST_RESP: begin
                    // resp_valid rises one cycle after entry, once the read register has settled.
                    if (r_resp_valid && resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                    end else begin
                        r_resp_valid <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_enter_resp) r_err <= !addr_ok(w_rd_addr, BASE_ADDR, DEPTH_W);
        end
    end

    ifu_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_ld_ok),
        .i_waddr (w_ld_idx),
        .i_wdata (load_data),
        .i_re    (w_enter_resp),
        .i_raddr (w_rd_idx),
        .o_rdata (w_rdata)
    );

    assign resp_valid = r_resp_valid;
    assign resp_err   = r_err;
    assign resp_data  = r_err ? 32'h0 : w_rdata;

endmodule

// File: tb/tb_ifu_mem_responder.sv
// Bench for ifu_mem_responder: two instances (LATENCY 1 and 3) sharing the load port.
module tb_ifu_mem_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid  [2];
    logic [31:0] req_addr   [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [31:0] resp_data  [2];
    logic        resp_err   [2];
    logic        resp_ready [2];
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] shadow [DEPTH];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;
    vec_t tab [9];

    always #5 clk = ~clk;

    ifu_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_addr(req_addr[0]), .req_ready(req_ready[0]),
        .resp_valid(resp_valid[0]), .resp_data(resp_data[0]), .resp_err(resp_err[0]),
        .resp_ready(resp_ready[0]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    ifu_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_addr(req_addr[1]), .req_ready(req_ready[1]),
        .resp_valid(resp_valid[1]), .resp_data(resp_data[1]), .resp_err(resp_err[1]),
        .resp_ready(resp_ready[1]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic bit bad_addr(input logic [31:0] a);
        longint unsigned off;
        if (a[1:0] != 2'b00) return 1'b1;
        if (a < BASE) return 1'b1;
        off = longint'(a) - longint'(BASE);
        return (off / 4) >= DEPTH;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7)       return 32'(4 * $urandom_range(0, DEPTH - 1));
        else if (r == 7) return 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
        else if (r == 8) return 32'(4 * DEPTH + 4 * $urandom_range(0, DEPTH - 1));
        else             return 32'($urandom);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] dat);
        load_en = 1'b1; load_addr = a; load_data = dat;
        tick();
        load_en = 1'b0;
        if (!bad_addr(a)) shadow[widx(a)] = dat;
    endtask

    // k0 = edges already elapsed since the accept edge
    task automatic wait_resp(input int d, input int k0, input logic [31:0] ed, input logic ee,
                             input string nm);
        int k;
        k = k0;
        while (!resp_valid[d] && k < 40) begin tick(); k++; end
        chk({nm, "_latency"}, k, 1 + lat(d));
        chk({nm, "_data"}, resp_data[d], ed);
        chk({nm, "_err"}, resp_err[d], ee);
        resp_ready[d] = 1'b1;
        tick();
        resp_ready[d] = 1'b0;
        chk({nm, "_drop"}, resp_valid[d], 0);
    endtask

    task automatic accept(input int d, input logic [31:0] a, input string nm);
        int k;
        req_valid[d] = 1'b1; req_addr[d] = a;
        #1;
        k = 0;
        while (!req_ready[d] && k < 20) begin tick(); k++; end
        chk({nm, "_ready"}, req_ready[d], 1);
        tick();
        req_valid[d] = 1'b0;
    endtask

    task automatic fetch(input int d, input logic [31:0] a, input logic [31:0] ed,
                         input logic ee, input string nm);
        accept(d, a, nm);
        wait_resp(d, 0, ed, ee, nm);
    endtask

    task automatic rand_run(input int d, input int n);
        bit busy, vis, hs, ld, ee, drain;
        int acc;
        logic [31:0] maddr, ed;
        busy = 0; acc = 0; maddr = '0; ed = '0; ee = 0;
        for (int t = 0; t < n + 20; t++) begin
            drain = (t >= n);
            ld = !drain && ($urandom_range(0, 3) == 0);
            load_en = ld; load_addr = rand_addr(); load_data = $urandom;
            req_valid[d]  = !drain && ($urandom_range(0, 1) == 1);
            req_addr[d]   = rand_addr();
            resp_ready[d] = drain || ($urandom_range(0, 2) != 0);
            #1;
            vis = busy && (t >= acc + lat(d) + 2);
            chk("rnd_ready", req_ready[d], !busy && !ld);
            chk("rnd_valid", resp_valid[d], vis);
            if (vis) begin
                chk("rnd_data", resp_data[d], ed);
                chk("rnd_err", resp_err[d], ee);
            end
            hs = vis && resp_ready[d];
            if (!busy && req_valid[d] && !ld) begin busy = 1; acc = t; maddr = req_addr[d]; end
            if (busy && t == acc + lat(d)) begin
                ee = bad_addr(maddr);
                ed = ee ? 32'h0 : shadow[widx(maddr)];
            end
            if (hs) busy = 0;
            if (ld && !bad_addr(load_addr)) shadow[widx(load_addr)] = load_data;
            tick();
        end
        load_en = 1'b0; req_valid[d] = 1'b0; resp_ready[d] = 1'b0;
        chk("rnd_drained", busy, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] bp_data;
        bit seen;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_addr[d] = '0; resp_ready[d] = 1'b0;
        end
        load_en = 1'b0; load_addr = '0; load_data = '0;

        tab[0] = '{32'h0000_0008, 32'h0050_0093, 1'b0};
        tab[1] = '{32'h0000_0000, 32'hA000_0000, 1'b0};
        tab[2] = '{32'h0000_003C, 32'hA000_000F, 1'b0};
        tab[3] = '{32'h0000_0010, 32'h0000_0001, 1'b0};
        tab[4] = '{32'h0000_0006, 32'h0000_0000, 1'b1};
        tab[5] = '{32'h0000_0040, 32'h0000_0000, 1'b1};
        tab[6] = '{32'h0000_0001, 32'h0000_0000, 1'b1};
        tab[7] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
        tab[8] = '{32'h0000_003E, 32'h0000_0000, 1'b1};

        // reset
        rst = 1'b1;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", req_ready[d], 0);
            chk("rst_valid", resp_valid[d], 0);
            chk("rst_data", resp_data[d], 0);
            chk("rst_err", resp_err[d], 0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_ready0", req_ready[0], 1);
        chk("post_rst_ready1", req_ready[1], 1);

        for (int i = 0; i < DEPTH; i++) do_load(32'(4 * i), 32'hA000_0000 | 32'(i));
        do_load(32'h8, 32'h0050_0093);
        do_load(32'h10, 32'h0000_0001);

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 9; i++) fetch(d, tab[i].addr, tab[i].data, tab[i].err, "vec");

        // dropped loads: misaligned and out of range (would alias word 0 if not decoded)
        do_load(32'h6, 32'hDEAD_BEEF);
        do_load(32'h40, 32'h0BAD_0BAD);
        fetch(0, 32'h4, 32'hA000_0001, 1'b0, "badld_w1");
        fetch(0, 32'h8, 32'h0050_0093, 1'b0, "badld_w2");
        fetch(0, 32'h0, 32'hA000_0000, 1'b0, "badld_w0");

        // a load blocks accept in the same cycle only
        load_en = 1'b1; load_addr = 32'h44; load_data = '0;
        req_valid[0] = 1'b1; req_addr[0] = 32'h8;
        #1;
        chk("load_blocks_ready", req_ready[0], 0);
        tick();
        load_en = 1'b0;
        #1;
        chk("load_unblocks_ready", req_ready[0], 1);
        req_valid[0] = 1'b0;
        fetch(0, 32'h8, 32'h0050_0093, 1'b0, "after_block");

        // backpressure, with a competing request held on the bus
        accept(0, 32'h8, "bp");
        req_valid[0] = 1'b1; req_addr[0] = 32'hC;
        tick(); tick();
        chk("bp_valid_first", resp_valid[0], 1);
        bp_data = resp_data[0];
        chk("bp_data_first", bp_data, 32'h0050_0093);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid_hold", resp_valid[0], 1);
            chk("bp_data_hold", resp_data[0], 32'h0050_0093);
            chk("bp_ready_low", req_ready[0], 0);
        end
        resp_ready[0] = 1'b1;
        tick();
        resp_ready[0] = 1'b0;
        chk("bp_hs_drop", resp_valid[0], 0);
        chk("bp_next_ready", req_ready[0], 1);
        tick();
        req_valid[0] = 1'b0;
        wait_resp(0, 0, 32'hA000_0003, 1'b0, "bp_next");

        // load/fetch race on the RESP-entry edge (LATENCY=3): old data
        accept(1, 32'h10, "race_late");
        tick(); tick();
        load_en = 1'b1; load_addr = 32'h10; load_data = 32'h2;
        tick();
        load_en = 1'b0; shadow[4] = 32'h2;
        wait_resp(1, 3, 32'h1, 1'b0, "race_late");

        // one edge earlier: new data
        do_load(32'h10, 32'h1);
        accept(1, 32'h10, "race_early");
        tick();
        load_en = 1'b1; load_addr = 32'h10; load_data = 32'h2;
        tick();
        load_en = 1'b0; shadow[4] = 32'h2;
        wait_resp(1, 2, 32'h2, 1'b0, "race_early");

        // reset while waiting: response abandoned, array kept
        accept(1, 32'h8, "midrst");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (resp_valid[1]) seen = 1;
            tick();
        end
        chk("midrst_no_resp", seen, 0);
        chk("midrst_ready", req_ready[1], 1);
        fetch(1, 32'h8, 32'h0050_0093, 1'b0, "midrst_w2");
        fetch(1, 32'h3C, 32'hA000_000F, 1'b0, "midrst_w15");

        rand_run(1, 300);
        rand_run(0, 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_mem_responder.md
Name: ifu_mem_responder

Overview:
- Instruction-memory responder: the slave end of the fetch interface that the IFU drives.
- Accepts one word-fetch request at a time, looks it up in an internal word array, and returns the data after a fixed, parameterized latency.
- Holds the response until the IFU consumes it.
- Array is filled through a separate load port (testbench or boot loader) before and during execution.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two, ≥2).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.
- LATENCY, 1, extra wait cycles between request accept and response (0..15).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  IFU presents a fetch request.
- req_addr  input  32  byte address of the fetch.
- req_ready  output  1  responder can accept a request this cycle.
- resp_valid  output  1  resp_data/resp_err valid.
- resp_data  output  32  fetched instruction word.
- resp_err  output  1  access fault (misaligned or out of range).
- resp_ready  input  1  IFU consumes the response.
- load_en  input  1  write one word into the array.
- load_addr  input  32  byte address for load.
- load_data  input  32  word to write.

Behaviour:
- Clock clk, reset rst: synchronous, active-high, single clock domain.
- Reset values: req_ready=0 during rst, 1 in the first cycle after; resp_valid=0, resp_data=0, resp_err=0; state=IDLE; counter=0. The array is not reset.
- FSM states:
  - IDLE: req_ready = !load_en.
  - WAIT: req_ready=0.
  - RESP: req_ready=0.
- Transitions:
  - Accept on the edge where req_valid && req_ready. Latch req_addr.
  - If LATENCY=0, go to RESP; otherwise go to WAIT with cnt=LATENCY-1.
  - WAIT: cnt decrements each cycle. When cnt==0, go to RESP.
  - RESP: hold resp_valid=1 with data and err stable until the resp_ready edge, then go to IDLE and drive resp_valid=0 the next cycle.
  - No accept while in RESP, so a new request is accepted no earlier than the cycle after the response handshake.
- Timing: accept on edge N → resp_valid high starting after edge N+1+LATENCY.
- Read sampling: the array is read on the edge that enters RESP, and resp_data is registered on that edge. A load write on that same edge to the same word is not visible (old data returned). A write on any earlier edge is visible.
- Address decode, where off = addr - BASE_ADDR (32-bit wrap) and idx = off[log2(DEPTH)+1:2]:
  - in range iff addr ≥ BASE_ADDR and off>>2 < DEPTH.
  - misaligned iff addr[1:0] ≠ 0.
  - misaligned or out of range → resp_err=1, resp_data=32'h0. The response still completes normally.
- Load port:
  - load_en writes array[idx(load_addr)] on the edge.
  - Misaligned or out-of-range loads are silently dropped.
  - Loads are allowed in any state.
  - A load blocks a new accept in the same cycle only.
- Reset mid-operation: any pending or held response is abandoned (no resp_valid after reset). Array contents are retained.
- req_addr is a don't-care when req_valid=0. req_valid may drop without being accepted (no penalty).

Optional Feature:
- Macro: IFU_MEM_RAND_DELAY_EN.
- Defined:
  - An 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on rst) advances every cycle.
  - On accept, cnt loads LATENCY + lfsr[1:0], giving 0..3 extra wait cycles.
  - When LATENCY=0 and lfsr[1:0]≠0, the FSM enters WAIT.
- Undefined: fixed latency exactly as specified above; no LFSR logic.

Decomposition:
- Shared package ifu_mem_pkg:
  - state encoding IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - LFSR seed/taps constants.
  - helper function for in-range/aligned decode, shared with the load path.
- One natural sub-module: ifu_mem_array (single write port, single registered-read port, DEPTH × 32). The FSM, counter and LFSR stay in the top.

Test Plan:
- Reset/idle: rst held 3 cycles → resp_valid=0, resp_data=0, resp_err=0; req_ready=1 on the first cycle after release.
- Basic fetch, LATENCY=1: load 0x8→32'h00500093; req 0x8 accepted on edge N → resp_valid high after edge N+2 with resp_data=32'h00500093, resp_err=0.
- Backpressure: resp_ready=0 for 5 cycles → resp_valid and resp_data stable throughout; req_ready=0; req_valid with 0xC ignored; after the handshake, the 0xC request is accepted the next cycle.
- Faults: req 0x6 → resp_err=1, data 0. Req BASE_ADDR+4*DEPTH → resp_err=1. Load to 0x6 leaves the array unchanged.
- Load/fetch race, LATENCY=3: fetch 0x10 (old value 32'h1); load 32'h2 on the RESP-entry edge → returns 32'h1. Load 32'h2 one edge earlier → returns 32'h2.
- Reset mid-operation: rst asserted while in WAIT → no response ever appears; the next fetch completes with the correct data and the array contents are preserved.
